// File: rtl/sd_block_scheduler.sv
//============================================================================
// Module  : sd_block_scheduler
// Purpose : Arbitrates USB-side block write/read requests onto a single SD
//           block interface over a circular region of NUM_BLKS blocks.
// Option  : SD_SCHED_TIMEOUT_EN adds a per-block watchdog and an ERR state.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module sd_block_scheduler #(
   parameter int NUM_BLKS    = 1024,
   parameter int ADDR_W      = 16,
   parameter int BASE_BLK    = 0,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_init_done,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic              write_done,
   input  logic              read_done,
   input  logic              err_clr,
   output logic              sd_write,
   output logic              sd_read,
   output logic [ADDR_W-1:0] blk_addr,
   output logic              wr_gnt,
   output logic              rd_gnt,
   output logic              wr_ack,
   output logic              rd_ack,
   output logic [ADDR_W-1:0] blk_count,
   output logic              full,
   output logic              empty,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_ISSUE_WR = 3'd1;
   localparam logic [2:0] c_WAIT_WR  = 3'd2;
   localparam logic [2:0] c_ISSUE_RD = 3'd3;
   localparam logic [2:0] c_WAIT_RD  = 3'd4;
   localparam logic [2:0] c_ACK      = 3'd5;
   localparam logic [2:0] c_ERR      = 3'd6;

   localparam logic [ADDR_W-1:0] c_NUM  = ADDR_W'(NUM_BLKS);
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_BLKS - 1);
   localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_BLK);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              last_wr_q, last_wr_d;   // 1: last block served was a write
   logic              w_elig_wr, w_elig_rd;

`ifdef SD_SCHED_TIMEOUT_EN
   localparam int c_TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

   logic [c_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic               tmo_err_q, tmo_err_d;
`else
   logic w_unused;
   assign w_unused = err_clr | (TIMEOUT_CYC == 0);
`endif

   assign w_elig_wr = wr_req & ~full;
   assign w_elig_rd = rd_req & ~empty;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      addr_d    = addr_q;
      last_wr_d = last_wr_q;
`ifdef SD_SCHED_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      case (state_q)
         c_IDLE: begin
            if (spi_init_done) begin
               // With both eligible, serve the opposite of whatever went last
               if (w_elig_wr && (!w_elig_rd || !last_wr_q)) begin
                  state_d = c_ISSUE_WR;
                  addr_d  = c_BASE + wr_ptr_q;
               end else if (w_elig_rd) begin
                  state_d = c_ISSUE_RD;
                  addr_d  = c_BASE + rd_ptr_q;
               end
            end
         end
         c_ISSUE_WR: begin
            state_d = c_WAIT_WR;
`ifdef SD_SCHED_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         c_ISSUE_RD: begin
            state_d = c_WAIT_RD;
`ifdef SD_SCHED_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         c_WAIT_WR: begin
            if (write_done) begin
               state_d   = c_ACK;
               wr_ptr_d  = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + 1'b1;
               count_d   = count_q + 1'b1;
               last_wr_d = 1'b1;
            end
`ifdef SD_SCHED_TIMEOUT_EN
            else if (tmo_cnt_q == c_TMO_LAST) begin
               state_d   = c_ERR;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         c_WAIT_RD: begin
            if (read_done) begin
               state_d   = c_ACK;
               rd_ptr_d  = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + 1'b1;
               count_d   = count_q - 1'b1;
               last_wr_d = 1'b0;
            end
`ifdef SD_SCHED_TIMEOUT_EN
            else if (tmo_cnt_q == c_TMO_LAST) begin
               state_d   = c_ERR;
               tmo_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         c_ACK: begin
            state_d = c_IDLE;
         end
         c_ERR: begin
`ifdef SD_SCHED_TIMEOUT_EN
            if (err_clr) begin
               state_d   = c_IDLE;
               tmo_err_d = 1'b0;
            end
`else
            state_d = c_IDLE;
`endif
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= c_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         addr_q    <= c_BASE;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         last_wr_q <= last_wr_d;
      end
   end

`ifdef SD_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end
   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign sd_write  = (state_q == c_ISSUE_WR);
   assign sd_read   = (state_q == c_ISSUE_RD);
   assign wr_gnt    = (state_q == c_ISSUE_WR) || (state_q == c_WAIT_WR);
   assign rd_gnt    = (state_q == c_ISSUE_RD) || (state_q == c_WAIT_RD);
   assign wr_ack    = (state_q == c_ACK) &&  last_wr_q;
   assign rd_ack    = (state_q == c_ACK) && !last_wr_q;
   assign blk_addr  = addr_q;
   assign blk_count = count_q;
   assign full      = (count_q == c_NUM);
   assign empty     = (count_q == '0);
   assign busy      = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sd_block_scheduler.sv
//============================================================================
// Module  : tb_sd_block_scheduler
// Purpose : Directed + randomized bench for sd_block_scheduler against a
//           FIFO-occupancy reference model. Build with SD_SCHED_TIMEOUT_EN
//           to include the watchdog sequence.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_sd_block_scheduler;

   localparam int NB   = 4;
   localparam int AW   = 16;
   localparam int BASE = 16;
   localparam int TMO  = 100;

   logic          clk = 1'b0;
   logic          rst, spi_init_done, wr_req, rd_req, write_done, read_done, err_clr;
   logic          sd_write, sd_read, wr_gnt, rd_gnt, wr_ack, rd_ack;
   logic          full, empty, busy, timeout_err;
   logic [AW-1:0] blk_addr, blk_count;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: the region as a circular queue of stored blocks
   int m_count, m_wptr, m_rptr;
   bit m_last_wr;

   sd_block_scheduler #(
      .NUM_BLKS(NB), .ADDR_W(AW), .BASE_BLK(BASE), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .spi_init_done(spi_init_done),
      .wr_req(wr_req), .rd_req(rd_req), .write_done(write_done),
      .read_done(read_done), .err_clr(err_clr),
      .sd_write(sd_write), .sd_read(sd_read), .blk_addr(blk_addr),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_ack(wr_ack), .rd_ack(rd_ack),
      .blk_count(blk_count), .full(full), .empty(empty), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_count   = 0;
      m_wptr    = 0;
      m_rptr    = 0;
      m_last_wr = 1'b0;
   endtask

   task automatic model_serve(input bit is_wr);
      if (is_wr) begin
         m_count++;
         m_wptr = (m_wptr + 1) % NB;
      end else begin
         m_count--;
         m_rptr = (m_rptr + 1) % NB;
      end
      m_last_wr = is_wr;
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_count"}, blk_count, m_count);
      chk({tag, "_full"},  full,      m_count == NB);
      chk({tag, "_empty"}, empty,     m_count == 0);
   endtask

   // One request episode starting from IDLE; stray=1 injects done pulses that must be ignored
   task automatic run_txn(input bit w, input bit r, input int dly, input bit stray);
      bit ew, er, do_w;
      int n;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("idle_before_req", busy, 1'b0);
      ew = w && (m_count < NB);
      er = r && (m_count > 0);
      wr_req = w;
      rd_req = r;
      tick();
      if (!ew && !er) begin
         repeat (4) tick();
         chk("pending_no_wr", sd_write | wr_gnt, 1'b0);
         chk("pending_no_rd", sd_read | rd_gnt, 1'b0);
         chk("pending_busy", busy, 1'b0);
         chk_flags("pending");
         wr_req = 1'b0;
         rd_req = 1'b0;
         return;
      end
      do_w = ew && (!er || !m_last_wr);
      chk("issue_wr", sd_write, do_w);
      chk("issue_rd", sd_read, !do_w);
      chk("issue_addr", blk_addr, BASE + (do_w ? m_wptr : m_rptr));
      chk("issue_gnt", {wr_gnt, rd_gnt}, {do_w, !do_w});
      if (stray) begin
         write_done = 1'b1;
         read_done  = 1'b1;
      end
      tick();
      write_done = 1'b0;
      read_done  = 1'b0;
      chk("wait_pulse", sd_write | sd_read, 1'b0);
      chk("wait_gnt", {wr_gnt, rd_gnt}, {do_w, !do_w});
      chk("wait_addr", blk_addr, BASE + (do_w ? m_wptr : m_rptr));
      if (stray) begin
         if (do_w) read_done = 1'b1; else write_done = 1'b1;
         tick();
         write_done = 1'b0;
         read_done  = 1'b0;
         chk("stray_ignored", {wr_gnt, rd_gnt, wr_ack, rd_ack}, {do_w, !do_w, 2'b00});
      end
      repeat (dly) tick();
      if (do_w) write_done = 1'b1; else read_done = 1'b1;
      tick();
      write_done = 1'b0;
      read_done  = 1'b0;
      model_serve(do_w);
      chk("ack", {wr_ack, rd_ack}, {do_w, !do_w});
      chk("ack_gnt", {wr_gnt, rd_gnt}, 2'b00);
      chk_flags("ack");
      wr_req = 1'b0;
      rd_req = 1'b0;
      tick();
      chk("ack_pulse", {wr_ack, rd_ack, busy}, 3'b000);
   endtask

   initial begin
      bit any_start;
      model_reset();
      rst = 1'b1; spi_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      write_done = 1'b0; read_done = 1'b0; err_clr = 1'b0;
      repeat (3) tick();
      chk("rst_pulses", {sd_write, sd_read, wr_gnt, rd_gnt, wr_ack, rd_ack}, 6'b0);
      chk("rst_busy_err", {busy, timeout_err}, 2'b00);
      chk("rst_addr", blk_addr, BASE);
      chk_flags("rst");
      rst = 1'b0;

      // Requests are held off until the SD interface reports ready
      wr_req = 1'b1;
      any_start = 1'b0;
      repeat (50) begin
         tick();
         if (sd_write || busy) any_start = 1'b1;
      end
      chk("init_hold", any_start, 1'b0);
      spi_init_done = 1'b1;
      tick();
      chk("init_sd_write", sd_write, 1'b1);
      chk("init_addr", blk_addr, BASE);
      repeat (20) tick();
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      model_serve(1'b1);
      chk("init_ack", wr_ack, 1'b1);
      wr_req = 1'b0;
      tick();

      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk_flags("rst2");

      // Three writes then two reads
      repeat (3) run_txn(1'b1, 1'b0, 19, 1'b0);
      repeat (2) run_txn(1'b0, 1'b1, 19, 1'b0);
      chk("seq_count_end", blk_count, 1);

      // Both requesting: service must alternate
      run_txn(1'b1, 1'b0, 2, 1'b0);
      repeat (4) run_txn(1'b1, 1'b1, 3, 1'b1);

      // Fill to capacity, write must stall, then wrap both pointers
      while (m_count < NB) run_txn(1'b1, 1'b0, 1, 1'b0);
      chk("fill_full", full, 1'b1);
      run_txn(1'b1, 1'b0, 1, 1'b0);
      run_txn(1'b0, 1'b1, 1, 1'b0);
      run_txn(1'b1, 1'b0, 1, 1'b0);
      while (m_count > 0) run_txn(1'b0, 1'b1, 1, 1'b0);
      run_txn(1'b0, 1'b1, 1, 1'b0);

      // Asynchronous reset in the middle of a write
      wr_req = 1'b1;
      tick();
      chk("abort_issue", sd_write, 1'b1);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("abort_async", {busy, wr_gnt}, 2'b00);
      write_done = 1'b1;
      wr_req = 1'b0;
      tick();
      rst = 1'b0;
      write_done = 1'b0;
      model_reset();
      any_start = 1'b0;
      repeat (3) begin
         tick();
         if (wr_ack) any_start = 1'b1;
      end
      chk("abort_no_ack", any_start, 1'b0);
      chk("abort_addr", blk_addr, BASE);
      chk_flags("abort");
      run_txn(1'b1, 1'b0, 2, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end

`ifdef SD_SCHED_TIMEOUT_EN
      begin
         int exp_addr;
         while (m_count >= NB) run_txn(1'b0, 1'b1, 1, 1'b0);
         exp_addr = BASE + m_wptr;
         wr_req = 1'b1;
         tick();
         chk("tmo_issue", sd_write, 1'b1);
         repeat (TMO) tick();
         chk("tmo_not_yet", {timeout_err, wr_gnt}, 2'b01);
         tick();
         chk("tmo_err", {timeout_err, busy, wr_ack}, 3'b110);
         chk_flags("tmo");
         repeat (5) tick();
         chk("tmo_sticky", {timeout_err, busy}, 2'b11);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         chk("tmo_clr", {timeout_err, busy}, 2'b00);
         tick();
         chk("tmo_reissue", sd_write, 1'b1);
         chk("tmo_reissue_addr", blk_addr, exp_addr);
         tick();
         write_done = 1'b1;
         tick();
         write_done = 1'b0;
         model_serve(1'b1);
         chk("tmo_ack", wr_ack, 1'b1);
         chk_flags("tmo_done");
         wr_req = 1'b0;
         tick();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
